// File: rtl/distribute_one_hot_seq.sv
// One-word-in, N-lane-out distributor: each lane is a single-entry register loaded by a destination mask.
// Optional build macro MULTICAST_EN allows multi-bit masks; the default build accepts one-hot masks only.
module distribute_one_hot_seq #(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_OUTPUT_DATA = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_valid,
  input  logic [DATA_WIDTH-1:0]                 i_data_bus,
  output logic                                  o_ready,
  input  logic                                  i_en,
  input  logic [NUM_OUTPUT_DATA-1:0]            i_cmd,
  output logic [NUM_OUTPUT_DATA-1:0]            o_valid,
  output logic [NUM_OUTPUT_DATA*DATA_WIDTH-1:0] o_data_bus,
  input  logic [NUM_OUTPUT_DATA-1:0]            i_ready,
  output logic                                  o_err,
  output logic [7:0]                            o_drop_cnt
);

  localparam logic [NUM_OUTPUT_DATA-1:0] CMD_ONE = NUM_OUTPUT_DATA'(1);

  logic                       cmd_legal;
  logic [NUM_OUTPUT_DATA-1:0] lane_free;
  logic                       sel_free;
  logic                       accept;
  logic                       drop;
  logic [NUM_OUTPUT_DATA-1:0] load;

`ifdef MULTICAST_EN
  assign cmd_legal = |i_cmd;
`else
  assign cmd_legal = (i_cmd != '0) && ((i_cmd & (i_cmd - CMD_ONE)) == '0);
`endif

  // An illegal mask touches no lane, so it is never held off by lane backpressure.
  assign lane_free = ~o_valid | i_ready;
  assign sel_free  = &(lane_free | ~i_cmd);
  assign o_ready   = i_en & (~cmd_legal | sel_free);
  assign accept    = i_valid & o_ready;
  assign drop      = accept & ~cmd_legal;
  assign load      = (accept && cmd_legal) ? i_cmd : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: lane data is reset as well, because an empty lane must present all-zero data.
      o_valid    <= '0;
      o_data_bus <= '0;
      o_err      <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      for (int j = 0; j < NUM_OUTPUT_DATA; j++) begin
        if (load[j]) begin
          o_valid[j]                               <= 1'b1;
          o_data_bus[j*DATA_WIDTH +: DATA_WIDTH]   <= i_data_bus;
        end else if (o_valid[j] && i_ready[j]) begin
          o_valid[j]                               <= 1'b0;
          o_data_bus[j*DATA_WIDTH +: DATA_WIDTH]   <= '0;
        end
      end
      o_err <= drop;
      if (drop && (o_drop_cnt != 8'hFF)) begin
        o_drop_cnt <= o_drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_distribute_one_hot_seq.sv
// Self-checking bench for distribute_one_hot_seq: directed steps followed by random traffic
// compared against a lane-array reference model.
module tb_distribute_one_hot_seq;

  localparam int DW = 32;
  localparam int N  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_valid;
  logic [DW-1:0]     i_data_bus;
  logic              o_ready;
  logic              i_en;
  logic [N-1:0]      i_cmd;
  logic [N-1:0]      o_valid;
  logic [N*DW-1:0]   o_data_bus;
  logic [N-1:0]      i_ready;
  logic              o_err;
  logic [7:0]        o_drop_cnt;

  distribute_one_hot_seq #(.DATA_WIDTH(DW), .NUM_OUTPUT_DATA(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_data_bus (i_data_bus),
    .o_ready    (o_ready),
    .i_en       (i_en),
    .i_cmd      (i_cmd),
    .o_valid    (o_valid),
    .o_data_bus (o_data_bus),
    .i_ready    (i_ready),
    .o_err      (o_err),
    .o_drop_cnt (o_drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: one entry per lane plus the error flag and drop count.
  logic          mv[N];
  logic [DW-1:0] md[N];
  logic          merr;
  int            mcnt;
  logic          obs_ready;
  int            cnt_before;

  task automatic check(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic legal_cmd(input logic [N-1:0] c);
`ifdef MULTICAST_EN
    return c != '0;
`else
    return $countones(c) == 1;
`endif
  endfunction

  function automatic logic model_ready();
    if (!i_en) return 1'b0;
    if (!legal_cmd(i_cmd)) return 1'b1;
    for (int j = 0; j < N; j++)
      if (i_cmd[j] && mv[j] && !i_ready[j]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < N; j++) begin
      mv[j] = 1'b0;
      md[j] = '0;
    end
    merr = 1'b0;
    mcnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    logic [N-1:0]    ev;
    logic [N*DW-1:0] ed;
    for (int j = 0; j < N; j++) begin
      ev[j]          = mv[j];
      ed[j*DW +: DW] = md[j];
    end
    check({tag, ".o_valid"},    o_valid,    ev);
    check({tag, ".o_data_bus"}, o_data_bus, ed);
    check({tag, ".o_err"},      o_err,      merr);
    check({tag, ".o_drop_cnt"}, o_drop_cnt, mcnt[7:0]);
  endtask

  // One clock: drive at negedge, check o_ready, advance model at posedge, check registers just after.
  task automatic cycle(input logic v, input logic en, input logic [N-1:0] cmd,
                       input logic [DW-1:0] d, input logic [N-1:0] rdy);
    logic acc;
    logic lg;
    @(negedge clk);
    i_valid    = v;
    i_en       = en;
    i_cmd      = cmd;
    i_data_bus = d;
    i_ready    = rdy;
    #1;
    obs_ready = o_ready;
    check("o_ready", o_ready, model_ready());
    lg  = legal_cmd(cmd);
    acc = v && model_ready();
    @(posedge clk);
    for (int j = 0; j < N; j++) begin
      if (acc && lg && cmd[j]) begin
        mv[j] = 1'b1;
        md[j] = d;
      end else if (mv[j] && rdy[j]) begin
        mv[j] = 1'b0;
        md[j] = '0;
      end
    end
    merr = acc && !lg;
    if (merr && mcnt < 255) mcnt++;
    #1;
    check_outputs("cycle");
  endtask

  initial begin
    logic [N-1:0] rc;
    int           k;
    rst        = 1'b1;
    i_valid    = 1'b0;
    i_en       = 1'b0;
    i_cmd      = '0;
    i_data_bus = '0;
    i_ready    = '0;
    model_reset();
    #1 rst = 1'b0;
    #12;
    check("reset.o_valid",    o_valid,    '0);
    check("reset.o_data_bus", o_data_bus, '0);
    check("reset.o_err",      o_err,      '0);
    check("reset.o_drop_cnt", o_drop_cnt, '0);
    @(negedge clk);
    rst = 1'b1;

    // Unicast load then drain.
    cycle(1'b1, 1'b1, 8'h04, 32'hA5A5_0001, 8'hFF);
    check("uni.valid", o_valid, 8'h04);
    check("uni.lane2", o_data_bus[2*DW +: DW], 32'hA5A5_0001);
    cycle(1'b0, 1'b1, 8'h00, 32'h0, 8'hFF);
    check("uni.drain.valid", o_valid, 8'h00);
    check("uni.drain.lane2", o_data_bus[2*DW +: DW], 32'h0);

    // Backpressure on lane 5, then reload with no bubble.
    cycle(1'b1, 1'b1, 8'h20, 32'h1111_0005, 8'h00);
    cycle(1'b1, 1'b1, 8'h20, 32'h2222_0005, 8'h00);
    check("bp.ready_low", obs_ready, 1'b0);
    check("bp.hold", o_data_bus[5*DW +: DW], 32'h1111_0005);
    cycle(1'b1, 1'b1, 8'h20, 32'h3333_0005, 8'h20);
    check("bp.ready_high", obs_ready, 1'b1);
    check("bp.reload.valid", o_valid, 8'h20);
    check("bp.reload.lane5", o_data_bus[5*DW +: DW], 32'h3333_0005);
    cycle(1'b0, 1'b1, 8'h00, 32'h0, 8'hFF);

    // Illegal all-zero command for three cycles.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 8'h00, 32'hDEAD_0000 + 32'(i), 8'hFF);
      check("ill.ready", obs_ready, 1'b1);
      check("ill.err", o_err, 1'b1);
    end
    check("ill.cnt3", o_drop_cnt, 8'd3);
    check("ill.novalid", o_valid, 8'h00);
    cycle(1'b0, 1'b1, 8'h00, 32'h0, 8'hFF);
    check("ill.err_clear", o_err, 1'b0);

    // Two-lane mask.
    cycle(1'b1, 1'b1, 8'h81, 32'h0000_BEEF, 8'h00);
`ifdef MULTICAST_EN
    check("mc.valid", o_valid, 8'h81);
    check("mc.lane0", o_data_bus[0 +: DW], 32'h0000_BEEF);
    check("mc.lane7", o_data_bus[7*DW +: DW], 32'h0000_BEEF);
    check("mc.cnt", o_drop_cnt, 8'd3);
`else
    check("mc.err", o_err, 1'b1);
    check("mc.cnt", o_drop_cnt, 8'd4);
    check("mc.novalid", o_valid, 8'h00);
`endif
    cycle(1'b0, 1'b1, 8'h00, 32'h0, 8'hFF);

    // Drop counter saturation.
    for (int i = 0; i < 300; i++) cycle(1'b1, 1'b1, 8'h00, 32'(i), 8'hFF);
    check("sat.cnt", o_drop_cnt, 8'd255);
    cycle(1'b0, 1'b1, 8'h00, 32'h0, 8'hFF);

    // Disable blocks acceptance but lanes still drain.
    cycle(1'b1, 1'b1, 8'h01, 32'hC0DE_0000, 8'h00);
    cnt_before = mcnt;
    cycle(1'b1, 1'b0, 8'h02, 32'hC0DE_0001, 8'h00);
    check("en.ready", obs_ready, 1'b0);
    check("en.cnt", o_drop_cnt, cnt_before[7:0]);
    check("en.valid", o_valid, 8'h01);
    cycle(1'b1, 1'b0, 8'h00, 32'hC0DE_0002, 8'hFF);
    check("en.drain", o_valid, 8'h00);
    check("en.illegal_blocked", o_err, 1'b0);

    // Asynchronous reset while lanes are full.
    cycle(1'b1, 1'b1, 8'h10, 32'hFACE_0004, 8'h00);
    cycle(1'b1, 1'b1, 8'h08, 32'hFACE_0003, 8'h00);
    i_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst.o_valid",    o_valid,    '0);
    check("arst.o_data_bus", o_data_bus, '0);
    check("arst.o_err",      o_err,      '0);
    check("arst.o_drop_cnt", o_drop_cnt, '0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b1, 1'b1, 8'h40, 32'h0F0F_0006, 8'h00);
    check("post_rst.first_accept", o_valid, 8'h40);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      k = $urandom_range(0, 9);
      if (k == 0)      rc = '0;
      else if (k < 3)  rc = N'($urandom);
      else             rc = N'(1) << $urandom_range(0, N-1);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) != 0, rc, $urandom, N'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/distribute_one_hot_seq.md
DISTRIBUTE_ONE_HOT_SEQ -- requirements
Module: distribute_one_hot_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width in bits of one data word.
REQ-002 Parameter NUM_OUTPUT_DATA, default 8, SHALL set the number of output lanes; it SHALL equal the i_cmd width.
REQ-003 Port clk  input  1  SHALL be the single rising-edge clock.
REQ-004 Port rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 Port i_valid  input  1  SHALL mark the input word as valid.
REQ-006 Port i_data_bus  input  DATA_WIDTH  SHALL carry the input word.
REQ-007 Port o_ready  output  1  SHALL mark that the input word is accepted this cycle if i_valid is high.
REQ-008 Port i_en  input  1  SHALL enable the switch.
REQ-009 Port i_cmd  input  NUM_OUTPUT_DATA  SHALL carry the destination lane mask; bit j selects lane j.
REQ-010 Port o_valid  output  NUM_OUTPUT_DATA  SHALL carry the per-lane output valid.
REQ-011 Port o_data_bus  output  NUM_OUTPUT_DATA*DATA_WIDTH  SHALL carry the per-lane data; lane j is bits [j*DATA_WIDTH +: DATA_WIDTH].
REQ-012 Port i_ready  input  NUM_OUTPUT_DATA  SHALL carry the per-lane downstream ready.
REQ-013 Port o_err  output  1  SHALL pulse when an illegal command is dropped.
REQ-014 Port o_drop_cnt  output  8  SHALL count dropped words.

Function
REQ-015 Each lane SHALL be a one-entry register with state EMPTY (o_valid[j]=0) or FULL (o_valid[j]=1).
REQ-016 lane_free[j] SHALL equal (~o_valid[j] | i_ready[j]).
REQ-017 o_ready SHALL equal i_en & AND over j of (lane_free[j] | ~i_cmd[j]); it is combinational from i_en, i_cmd, i_ready and lane state.
REQ-018 accept SHALL equal i_valid & o_ready.
REQ-019 On accept of a legal command, every selected lane SHALL load i_data_bus and go FULL on the next edge; latency is 1 cycle.
REQ-020 A FULL lane with i_ready[j]=1 and no reload SHALL go EMPTY and SHALL zero its data field on the next edge.
REQ-021 A FULL lane with i_ready[j]=1 and a reload in the same cycle SHALL stay FULL with the new word, with no bubble.
REQ-022 A FULL lane with i_ready[j]=0 SHALL hold its data and valid unchanged.
REQ-023 With i_en=0, o_ready SHALL be 0 and no word SHALL be accepted; FULL lanes SHALL still drain per REQ-020.
REQ-024 An all-zero i_cmd SHALL be illegal: o_ready = i_en, and the word is accepted and dropped with no lane written.
REQ-025 On an illegal accept, o_err SHALL be 1 in the following cycle only, and o_drop_cnt SHALL increment, saturating at 255.
REQ-026 Unselected lanes SHALL be unaffected by an accept.

Reset
REQ-027 When rst=0, regardless of clk, o_valid SHALL be 0, o_data_bus 0, o_err 0 and o_drop_cnt 0.
REQ-028 Reset mid-transfer SHALL discard all FULL lanes; no word SHALL be delivered after rst deasserts unless it is re-accepted.
REQ-029 The first accept after reset SHALL be possible on the first rising edge with rst=1.

Configuration
REQ-030 The macro SHALL be MULTICAST_EN.
REQ-031 With MULTICAST_EN defined, any nonzero i_cmd SHALL be legal, and the word SHALL be written to all selected lanes in the same edge, with backpressure per REQ-017.
REQ-032 Without MULTICAST_EN, only one-hot i_cmd SHALL be legal.
REQ-033 Without MULTICAST_EN, a multi-bit i_cmd SHALL be treated as illegal per REQ-024/025; o_ready for it SHALL equal i_en.

Verification
REQ-034 Unicast: i_en=1, i_cmd=8'h04, i_valid=1, data=32'hA5A5_0001, i_ready=8'hFF -> next cycle o_valid=8'h04 and lane 2 data=32'hA5A5_0001; following cycle o_valid=0 and lane 2 data=0.
REQ-035 Backpressure: lane 5 FULL, i_ready[5]=0, i_cmd=8'h20 -> o_ready=0 and lane 5 holds its data; raise i_ready[5] -> o_ready=1 and new word in lane 5 next cycle with no bubble.
REQ-036 Illegal: i_cmd=8'h00 with i_valid=1 for 3 cycles -> o_ready=1, o_err high for 3 cycles starting one cycle later, o_drop_cnt=3, o_valid=0; 300 drops -> o_drop_cnt=255.
REQ-037 Multicast: i_cmd=8'h81, data=32'h0000_BEEF -> with MULTICAST_EN, o_valid=8'h81 and both lanes=32'h0000_BEEF; without it, o_err=1 and o_drop_cnt+1.
REQ-038 Reset/enable: rst=0 asynchronously while lanes are FULL -> outputs immediately 0; i_en=0 with i_valid=1 -> o_ready=0 and o_drop_cnt unchanged.
